// File: rtl/ps2_poly_keymap_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_poly_keymap_if
// Purpose  : Scan-code strobe bus from the PS/2 controller to the keymap.
// Signals  : ps2_key_pressed - one-cycle strobe, ps2_key_data is valid
//            ps2_key_data    - received scan-code byte
// Modports : master - PS/2 controller side (drives the strobe and byte)
//            slave  - keymap side (samples the strobe and byte)
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_poly_keymap_if;
  logic       ps2_key_pressed;
  logic [7:0] ps2_key_data;

  modport master (output ps2_key_pressed, output ps2_key_data);
  modport slave  (input  ps2_key_pressed, input  ps2_key_data);
endinterface
`default_nettype wire

// File: rtl/ps2_poly_keymap.sv
`default_nettype none
// ============================================================================
// Module   : ps2_poly_keymap
// Purpose  : Polyphonic PS/2 key decoder. Parses make/break/E0 prefixes,
//            allocates up to NUM_VOICES held note keys into voice slots and
//            emits de-repeated single-cycle control pulses.
// Ports    : CLOCK_50            - system clock
//            resetn              - asynchronous active-low reset
//            ps2                 - scan-code strobe bus (slave modport)
//            voice_note          - note of slot i at [i*NOTE_W +: NOTE_W]
//            voice_gate          - slot i is held
//            voice_on/voice_off  - one-cycle allocate / release pulses
//            note_dropped        - one-cycle pulse, make with all slots busy
//            octave_*/ADSR_*     - one-cycle control pulses
//            ADSR_selector       - selected ADSR parameter (level)
// Revision : 1.0 - initial release
// ============================================================================
module ps2_poly_keymap #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 4,
  parameter int SEL_W      = 3
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  ps2_poly_keymap_if.slave             ps2,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_on,
  output logic [NUM_VOICES-1:0]        voice_off,
  output logic                         note_dropped,
  output logic                         octave_minus_minus,
  output logic                         octave_plus_plus,
  output logic                         ADSR_minus_minus,
  output logic                         ADSR_plus_plus,
  output logic [SEL_W-1:0]             ADSR_selector
);

  localparam logic [7:0] c_BRK   = 8'hF0;
  localparam logic [7:0] c_EXT   = 8'hE0;
  localparam logic [7:0] c_PANIC = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;
  logic   w_do_make, w_do_break;

  // --------------------------------------------------------------------------
  // Prefix parser
  // --------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_make   = 1'b0;
    w_do_break  = 1'b0;
    if (ps2.ps2_key_pressed) begin
      case (r_state)
        ST_IDLE: begin
          if (ps2.ps2_key_data == c_BRK)      w_state_nxt = ST_BRK;
          else if (ps2.ps2_key_data == c_EXT) w_state_nxt = ST_EXT;
          else                                w_do_make   = 1'b1;
        end
        ST_BRK: begin
          w_do_break  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        // Extended keys are not part of the keymap; only the prefix
        // sequence is tracked so the following byte is swallowed.
        ST_EXT:     w_state_nxt = (ps2.ps2_key_data == c_BRK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Key decode. w_ctl_hit bit order: octave--, octave++, ADSR--, ADSR++.
  // --------------------------------------------------------------------------
  logic              w_is_note;
  logic [NOTE_W-1:0] w_note_code;
  logic [3:0]        w_ctl_hit;
  logic              w_is_sel;
  logic [SEL_W-1:0]  w_sel_val;
  logic              w_is_panic;

  always_comb begin
    w_is_note   = 1'b0;
    w_note_code = '0;
    w_ctl_hit   = 4'b0000;
    w_is_sel    = 1'b0;
    w_sel_val   = '0;
    w_is_panic  = (ps2.ps2_key_data == c_PANIC);
    case (ps2.ps2_key_data)
      8'h1C: begin w_is_note = 1'b1; w_note_code = NOTE_W'(0);  end
      8'h1D: begin w_is_note = 1'b1; w_note_code = NOTE_W'(1);  end
      8'h1B: begin w_is_note = 1'b1; w_note_code = NOTE_W'(2);  end
      8'h24: begin w_is_note = 1'b1; w_note_code = NOTE_W'(3);  end
      8'h23: begin w_is_note = 1'b1; w_note_code = NOTE_W'(4);  end
      8'h2B: begin w_is_note = 1'b1; w_note_code = NOTE_W'(5);  end
      8'h2C: begin w_is_note = 1'b1; w_note_code = NOTE_W'(6);  end
      8'h34: begin w_is_note = 1'b1; w_note_code = NOTE_W'(7);  end
      8'h35: begin w_is_note = 1'b1; w_note_code = NOTE_W'(8);  end
      8'h33: begin w_is_note = 1'b1; w_note_code = NOTE_W'(9);  end
      8'h3C: begin w_is_note = 1'b1; w_note_code = NOTE_W'(10); end
      8'h3B: begin w_is_note = 1'b1; w_note_code = NOTE_W'(11); end
      8'h1A: w_ctl_hit = 4'b0001;
      8'h22: w_ctl_hit = 4'b0010;
      8'h21: w_ctl_hit = 4'b0100;
      8'h2A: w_ctl_hit = 4'b1000;
      8'h16: begin w_is_sel = 1'b1; w_sel_val = SEL_W'(0); end
      8'h1E: begin w_is_sel = 1'b1; w_sel_val = SEL_W'(1); end
      8'h26: begin w_is_sel = 1'b1; w_sel_val = SEL_W'(2); end
      8'h25: begin w_is_sel = 1'b1; w_sel_val = SEL_W'(3); end
      8'h2E: begin w_is_sel = 1'b1; w_sel_val = SEL_W'(4); end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Voice slot allocation
  // --------------------------------------------------------------------------
  logic [NUM_VOICES*NOTE_W-1:0] r_note, w_note_nxt;
  logic [NUM_VOICES-1:0]        r_gate, w_gate_nxt;
  logic [NUM_VOICES-1:0]        r_on, w_on_nxt;
  logic [NUM_VOICES-1:0]        r_off, w_off_nxt;
  logic                         r_drop, w_drop_nxt;
  logic [NUM_VOICES-1:0]        w_match;
  logic                         w_found;

  // A slot "matches" only while gated, so released slots keep their stale
  // note without ever blocking a fresh make of the same key.
  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_match
    assign w_match[gi] = r_gate[gi] && (r_note[gi*NOTE_W +: NOTE_W] == w_note_code);
  end

  always_comb begin
    w_note_nxt = r_note;
    w_gate_nxt = r_gate;
    w_on_nxt   = '0;
    w_off_nxt  = '0;
    w_drop_nxt = 1'b0;
    w_found    = 1'b0;
    if (w_do_make && w_is_note) begin
      // An already-held note is a typematic repeat: no retrigger.
      if (w_match == '0) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (!w_found && !r_gate[i]) begin
            w_found                       = 1'b1;
            w_gate_nxt[i]                 = 1'b1;
            w_note_nxt[i*NOTE_W +: NOTE_W] = w_note_code;
            w_on_nxt[i]                   = 1'b1;
          end
        end
        w_drop_nxt = !w_found;
      end
    end else if (w_do_make && w_is_panic) begin
      w_off_nxt  = r_gate;
      w_gate_nxt = '0;
    end else if (w_do_break && w_is_note) begin
      w_off_nxt  = w_match;
      w_gate_nxt = r_gate & ~w_match;
    end
  end

  // --------------------------------------------------------------------------
  // Control keys: held flags gate the pulses so auto-repeat makes are silent
  // --------------------------------------------------------------------------
  logic [3:0]       r_held, w_held_nxt;
  logic [3:0]       r_ctl_pulse, w_ctl_pulse_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;

  always_comb begin
    w_held_nxt      = r_held;
    w_ctl_pulse_nxt = 4'b0000;
    w_sel_nxt       = r_sel;
    if (w_do_make) begin
      w_ctl_pulse_nxt = w_ctl_hit & ~r_held;
      w_held_nxt      = r_held | w_ctl_hit;
      if (w_is_sel) w_sel_nxt = w_sel_val;
    end else if (w_do_break) begin
      w_held_nxt = r_held & ~w_ctl_hit;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_note      <= '0;
      r_gate      <= '0;
      r_on        <= '0;
      r_off       <= '0;
      r_drop      <= 1'b0;
      r_held      <= 4'b0000;
      r_ctl_pulse <= 4'b0000;
      r_sel       <= '0;
    end else begin
      r_note      <= w_note_nxt;
      r_gate      <= w_gate_nxt;
      r_on        <= w_on_nxt;
      r_off       <= w_off_nxt;
      r_drop      <= w_drop_nxt;
      r_held      <= w_held_nxt;
      r_ctl_pulse <= w_ctl_pulse_nxt;
      r_sel       <= w_sel_nxt;
    end
  end

  assign voice_note         = r_note;
  assign voice_gate         = r_gate;
  assign voice_on           = r_on;
  assign voice_off          = r_off;
  assign note_dropped       = r_drop;
  assign octave_minus_minus = r_ctl_pulse[0];
  assign octave_plus_plus   = r_ctl_pulse[1];
  assign ADSR_minus_minus   = r_ctl_pulse[2];
  assign ADSR_plus_plus     = r_ctl_pulse[3];
  assign ADSR_selector      = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_ps2_poly_keymap.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_poly_keymap
// Purpose  : Self-checking bench for ps2_poly_keymap against a byte-queue
//            reference model of the keymap behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_poly_keymap;
  localparam int NV = 4;
  localparam int NW = 4;
  localparam int SW = 3;
  localparam int OW = NV*NW + 3*NV + 5 + SW;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  ps2_poly_keymap_if ps2();

  logic [NV*NW-1:0] voice_note;
  logic [NV-1:0]    voice_gate, voice_on, voice_off;
  logic             note_dropped, octave_minus_minus, octave_plus_plus;
  logic             ADSR_minus_minus, ADSR_plus_plus;
  logic [SW-1:0]    ADSR_selector;

  ps2_poly_keymap #(.NUM_VOICES(NV), .NOTE_W(NW), .SEL_W(SW)) dut (
    .CLOCK_50           (CLOCK_50),
    .resetn             (resetn),
    .ps2                (ps2),
    .voice_note         (voice_note),
    .voice_gate         (voice_gate),
    .voice_on           (voice_on),
    .voice_off          (voice_off),
    .note_dropped       (note_dropped),
    .octave_minus_minus (octave_minus_minus),
    .octave_plus_plus   (octave_plus_plus),
    .ADSR_minus_minus   (ADSR_minus_minus),
    .ADSR_plus_plus     (ADSR_plus_plus),
    .ADSR_selector      (ADSR_selector)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  wire [OW-1:0] obs = {voice_note, voice_gate, voice_on, voice_off, note_dropped,
                       octave_minus_minus, octave_plus_plus, ADSR_minus_minus,
                       ADSR_plus_plus, ADSR_selector};

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [7:0] note_keys [12] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B,
                                 8'h2C, 8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B};
  logic [7:0] ctl_keys  [4]  = '{8'h1A, 8'h22, 8'h21, 8'h2A};
  logic [7:0] sel_keys  [5]  = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

  int         m_note  [NV];
  bit         m_gate  [NV];
  bit         m_on    [NV];
  bit         m_off   [NV];
  bit         m_drop;
  bit         m_hold  [4];
  bit         m_pulse [4];
  int         m_sel;
  logic [7:0] m_pfx [$];   // prefix bytes seen since the last complete key

  function automatic int note_of(input logic [7:0] b);
    for (int k = 0; k < 12; k++) if (note_keys[k] == b) return k;
    return -1;
  endfunction

  function automatic int ctl_of(input logic [7:0] b);
    for (int k = 0; k < 4; k++) if (ctl_keys[k] == b) return k;
    return -1;
  endfunction

  function automatic int sel_of(input logic [7:0] b);
    for (int k = 0; k < 5; k++) if (sel_keys[k] == b) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 0; m_gate[i] = 0; m_on[i] = 0; m_off[i] = 0;
    end
    for (int k = 0; k < 4; k++) begin m_hold[k] = 0; m_pulse[k] = 0; end
    m_drop = 0;
    m_sel  = 0;
    m_pfx.delete();
  endtask

  task automatic model_make(input logic [7:0] b);
    int  n, c, s;
    bit  held, placed;
    n = note_of(b); c = ctl_of(b); s = sel_of(b);
    if (n >= 0) begin
      held = 0;
      for (int i = 0; i < NV; i++) if (m_gate[i] && m_note[i] == n) held = 1;
      if (!held) begin
        placed = 0;
        for (int i = 0; i < NV; i++)
          if (!placed && !m_gate[i]) begin
            placed = 1; m_gate[i] = 1; m_note[i] = n; m_on[i] = 1;
          end
        if (!placed) m_drop = 1;
      end
    end
    if (c >= 0) begin
      if (!m_hold[c]) m_pulse[c] = 1;
      m_hold[c] = 1;
    end
    if (s >= 0) m_sel = s;
    if (b == 8'h76)
      for (int i = 0; i < NV; i++) if (m_gate[i]) begin m_gate[i] = 0; m_off[i] = 1; end
  endtask

  task automatic model_break(input logic [7:0] b);
    int n, c;
    n = note_of(b); c = ctl_of(b);
    if (n >= 0)
      for (int i = 0; i < NV; i++)
        if (m_gate[i] && m_note[i] == n) begin m_gate[i] = 0; m_off[i] = 1; end
    if (c >= 0) m_hold[c] = 0;
  endtask

  task automatic model_apply(input bit stb, input logic [7:0] b);
    for (int i = 0; i < NV; i++) begin m_on[i] = 0; m_off[i] = 0; end
    for (int k = 0; k < 4; k++) m_pulse[k] = 0;
    m_drop = 0;
    if (!stb) return;
    if (m_pfx.size() == 0) begin
      if (b == 8'hF0 || b == 8'hE0) m_pfx.push_back(b);
      else model_make(b);
    end else if (m_pfx.size() == 1 && m_pfx[0] == 8'hF0) begin
      model_break(b);
      m_pfx.delete();
    end else if (m_pfx.size() == 1 && b == 8'hF0) begin
      m_pfx.push_back(b);              // E0 F0 -> wait for the extended code
    end else begin
      m_pfx.delete();                  // extended key: swallowed
    end
  endtask

  function automatic logic [OW-1:0] exp_vec();
    logic [NV*NW-1:0] n;
    logic [NV-1:0]    g, on, off;
    logic [SW-1:0]    s;
    for (int i = 0; i < NV; i++) begin
      n[i*NW +: NW] = NW'(m_note[i]);
      g[i]   = m_gate[i];
      on[i]  = m_on[i];
      off[i] = m_off[i];
    end
    s = SW'(m_sel);
    return {n, g, on, off, m_drop, m_pulse[0], m_pulse[1], m_pulse[2], m_pulse[3], s};
  endfunction

  // One clock of stimulus; inputs change 1 time unit after the active edge.
  task automatic step(input bit stb, input logic [7:0] b);
    ps2.ps2_key_pressed = stb;
    ps2.ps2_key_data    = b;
    @(posedge CLOCK_50);
    #1;
    model_apply(stb, b);
    ps2.ps2_key_pressed = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ps2.ps2_key_pressed = 1'b0;
    @(posedge CLOCK_50);
    #1;
    model_reset();
    resetn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++;
    if (obs !== exp_vec() || obs !== '0) begin
      bad++; $display("FAIL reset: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_single_note();
    int seq [$] = '{'h1C, -1, 'hF0, 'h1C, -1};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i] >= 0, 8'(seq[i]));
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL single_note[%0d]: got %h want %h", i, obs, exp_vec());
      end
      if (i == 0) begin
        total++;
        if (voice_gate !== 4'b0001 || voice_on !== 4'b0001 || voice_note[3:0] !== 4'd0) begin
          bad++; $display("FAIL single_note_alloc: got gate=%b on=%b note=%0d want 0001 0001 0", voice_gate, voice_on, voice_note[3:0]);
        end
      end
      if (i == 3) begin
        total++;
        if (voice_gate !== 4'b0000 || voice_off !== 4'b0001) begin
          bad++; $display("FAIL single_note_release: got gate=%b off=%b want 0000 0001", voice_gate, voice_off);
        end
      end
    end
  endtask

  task automatic test_chord();
    int seq [$] = '{'h1C, 'h23, 'h34, 'h3B, 'h33, -1, 'hF0, 'h23, 'h33, -1};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i] >= 0, 8'(seq[i]));
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL chord[%0d]: got %h want %h", i, obs, exp_vec());
      end
      if (i == 4) begin
        total++;
        if (note_dropped !== 1'b1 || voice_note !== 16'hB740) begin
          bad++; $display("FAIL chord_full: got drop=%b notes=%h want 1 b740", note_dropped, voice_note);
        end
      end
      if (i == 8) begin
        total++;
        if (voice_on !== 4'b0010 || voice_note[7:4] !== 4'd9 || voice_gate !== 4'b1111) begin
          bad++; $display("FAIL chord_refill: got on=%b n1=%0d gate=%b want 0010 9 1111", voice_on, voice_note[7:4], voice_gate);
        end
      end
    end
  endtask

  task automatic test_typematic();
    int seq [$] = '{'h22, 'h22, -1, 'h22, 'hF0, 'h22, 'h1C, 'h1C, -1};
    int n_oct, n_on;
    n_oct = 0; n_on = 0;
    do_reset();
    foreach (seq[i]) begin
      step(seq[i] >= 0, 8'(seq[i]));
      n_oct += int'(octave_plus_plus);
      n_on  += int'(voice_on[0]) + int'(voice_on[1]);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL typematic[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
    total++;
    if (n_oct != 1 || n_on != 1) begin
      bad++; $display("FAIL typematic_count: got oct=%0d on=%0d want 1 1", n_oct, n_on);
    end
  endtask

  task automatic test_extended();
    int seq [$] = '{'hE0, 'h1C, 'hE0, 'hF0, 'h1C, -1, 'h1C};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i] >= 0, 8'(seq[i]));
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL extended[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
    total++;
    if (voice_gate !== 4'b0001 || voice_on !== 4'b0001) begin
      bad++; $display("FAIL extended_after: got gate=%b on=%b want 0001 0001", voice_gate, voice_on);
    end
  endtask

  task automatic test_panic();
    int seq [$] = '{'h1C, 'h23, 'h34, 'h76, -1, 'h76, 'hF0, 'h76, 'h26, -1};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i] >= 0, 8'(seq[i]));
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL panic[%0d]: got %h want %h", i, obs, exp_vec());
      end
      if (i == 3) begin
        total++;
        if (voice_gate !== 4'b0000 || voice_off !== 4'b0111) begin
          bad++; $display("FAIL panic_off: got gate=%b off=%b want 0000 0111", voice_gate, voice_off);
        end
      end
    end
    total++;
    if (ADSR_selector !== 3'd2) begin
      bad++; $display("FAIL panic_sel: got %0d want 2", ADSR_selector);
    end
  endtask

  task automatic test_back_to_back();
    int seq [$] = '{'h1C, 'h23, 'h34, 'h3B, 'hF0, 'h1C, 'h1D, 'hF0, 'h23,
                    'h21, 'h2A, 'h1A, 'h2E, 'hF0, 'h21, 'h21, 'h25, -1};
    do_reset();
    foreach (seq[i]) begin
      step(seq[i] >= 0, 8'(seq[i]));
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL back_to_back[%0d]: got %h want %h", i, obs, exp_vec());
      end
      if (i == 6) begin
        total++;
        if (voice_on !== 4'b0001 || voice_note[3:0] !== 4'd1) begin
          bad++; $display("FAIL back_to_back_realloc: got on=%b n0=%0d want 0001 1", voice_on, voice_note[3:0]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 8'h1C);
    step(1'b1, 8'hF0);
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs !== '0) begin
      bad++; $display("FAIL async_reset_immediate: got %h want 0", obs);
    end
    @(posedge CLOCK_50);
    #1;
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL async_reset_held: got %h want %h", obs, exp_vec());
    end
    resetn = 1'b1;
    step(1'b1, 8'h1C);
    total++;
    if (obs !== exp_vec() || voice_gate !== 4'b0001 || voice_on !== 4'b0001) begin
      bad++; $display("FAIL async_reset_make: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         stb;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      stb = 1'b1;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: b = note_keys[$urandom_range(0, 5)];
        4:          b = 8'hF0;
        5:          b = ($urandom_range(0, 3) == 0) ? 8'hE0 : 8'hF0;
        6:          b = ctl_keys[$urandom_range(0, 3)];
        7:          b = sel_keys[$urandom_range(0, 4)];
        8:          b = ($urandom_range(0, 3) == 0) ? 8'h76 : 8'($urandom);
        default:    begin b = 8'($urandom); stb = 1'b0; end
      endcase
      step(stb, b);
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL random[%0d] byte=%h stb=%0d: got %h want %h", i, b, stb, obs, exp_vec());
      end
    end
  endtask

  initial begin
    ps2.ps2_key_pressed = 1'b0;
    ps2.ps2_key_data    = 8'h00;
    model_reset();
    #2;
    test_reset();
    test_single_note();
    test_chord();
    test_typematic();
    test_extended();
    test_panic();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_poly_keymap.md
Name: ps2_poly_keymap

Overview:
- Successor to the single-note PS/2 key decoder. Consumes PS/2 scan-code strobes and runs a make/break/extended-prefix parser.
- Tracks up to NUM_VOICES simultaneously held note keys, each with its own note and gate.
- Emits single-cycle control pulses for octave and ADSR keys, with typematic auto-repeat suppressed.
- Sits between the PS/2 controller and the voice/ADSR engines, all on CLOCK_50.

Parameters:
- NUM_VOICES, 4, number of voice slots (1..8).
- NOTE_W, 4, width of the note code per voice (semitone 0..11).
- SEL_W, 3, width of ADSR_selector.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  reset; one clock; asynchronous, active-low.
- ps2_key_pressed  in  1  one-cycle strobe: ps2_key_data is valid.
- ps2_key_data  in  8  received scan-code byte.
- voice_note  out  NUM_VOICES*NOTE_W  note of slot i at bits [i*NOTE_W +: NOTE_W].
- voice_gate  out  NUM_VOICES  slot i is held.
- voice_on  out  NUM_VOICES  one-cycle pulse when slot i is allocated.
- voice_off  out  NUM_VOICES  one-cycle pulse when slot i is released.
- note_dropped  out  1  one-cycle pulse: note make arrived with all slots busy.
- octave_minus_minus, octave_plus_plus  out  1 each  one-cycle pulses.
- ADSR_minus_minus, ADSR_plus_plus  out  1 each  one-cycle pulses.
- ADSR_selector  out  SEL_W  selected ADSR parameter (registered level).

Behaviour:
- Reset (async, resetn=0): all outputs 0. Parser state IDLE. All slots free. Control-held flags cleared. Reset mid-sequence discards any pending F0/E0 prefix.
- Inputs are sampled only when ps2_key_pressed=1. All outputs update on that same clock edge (1-cycle latency). Pulses are high for exactly one cycle and return to 0 on the next edge.
- Parser FSM:
  - IDLE: F0 -> BRK; E0 -> EXT; otherwise process as MAKE, stay IDLE.
  - BRK: any byte -> process as BREAK -> IDLE.
  - EXT: F0 -> EXT_BRK; otherwise discard -> IDLE.
  - EXT_BRK: any byte -> discard -> IDLE.
- Note map (code -> note): 1C->0, 1D->1, 1B->2, 24->3, 23->4, 2B->5, 2C->6, 34->7, 35->8, 33->9, 3C->10, 3B->11.
- Control map:
  - 1A: octave_minus_minus.
  - 22: octave_plus_plus.
  - 21: ADSR_minus_minus.
  - 2A: ADSR_plus_plus.
  - 16/1E/26/25/2E: ADSR_selector = 0/1/2/3/4.
  - 76 (Esc): panic.
- Unmapped codes: ignored. Parser state still advances.
- Note MAKE:
  - If the note is already gated in any slot: ignore (typematic repeat, no retrigger).
  - Else, if a free slot exists: allocate the lowest-index free slot, set its note and gate, and pulse voice_on[i].
  - Else: pulse note_dropped; no slot changes.
- Note BREAK:
  - Every gated slot with a matching note: clear gate, pulse voice_off[i]. voice_note holds its last value.
  - BREAK for a non-held note: no effect.
- Control MAKE: pulse only if that key's held flag is 0, then set the flag. BREAK clears the flag. Repeat makes produce no pulse.
- ADSR select keys: update on every MAKE (idempotent). BREAK has no effect.
- Panic MAKE: clear all gates; pulse voice_off on every slot that was gated. Panic BREAK: no effect.
- A slot freed on edge N may be allocated by a strobe on edge N+1.
- NUM_VOICES=1 degenerates to monophonic; a second note while held -> note_dropped.

Test Plan:
- Reset, then strobe 1C -> voice_gate=0001, voice_note[3:0]=0, voice_on=0001 for 1 cycle. Then F0,1C -> voice_gate=0000, voice_off=0001 for 1 cycle.
- Hold chord: makes 1C,23,34,3B,33 -> slots 0..3 = 0,4,7,11, gate=1111, fifth make pulses note_dropped. Then F0,23 frees slot 1. Make 33 -> slot 1 note=9, voice_on=0010.
- Typematic: makes 22,22,22 then F0,22 -> octave_plus_plus pulses exactly once. Make 1C,1C -> one voice_on only.
- Extended prefix: E0,1C then E0,F0,1C -> no outputs change. A following 1C make allocates slot 0 normally.
- Panic: with gate=0111, make 76 -> gate=0000, voice_off=0111 for 1 cycle. Make 26 -> ADSR_selector=2.
- Async reset: assert resetn=0 between F0 and the next byte, release, strobe 1C -> treated as MAKE (slot 0 allocated); all outputs read 0 during reset.
